// File: rtl/stream_packer.sv
// stream_packer: packs RATIO narrow beats into one wide word, little-endian, with in_last early flush.
// Optional lane-valid mask output enabled by defining STREAM_PACKER_KEEP_EN.
module stream_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clear,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  output logic [IN_WIDTH*RATIO-1:0]     out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
`ifdef STREAM_PACKER_KEEP_EN
  output logic [RATIO-1:0]              out_keep,
`endif
  output logic [$clog2(RATIO):0]        fill
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int LB_RATIO  = $clog2(RATIO);

  logic [LB_RATIO-1:0]  cnt;
  logic [IN_WIDTH-1:0]  acc [RATIO-1];
  logic [OUT_WIDTH-1:0] merged;
  logic                 accept;
  logic                 close_word;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign close_word = accept && (in_last || (cnt == LB_RATIO'(RATIO - 1)));
  assign fill       = {1'b0, cnt};

  // The closing beat lands directly in the output word, so acc only ever needs RATIO-1 lanes.
  always_comb begin
    merged = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (LB_RATIO'(k) < cnt) merged[k*IN_WIDTH +: IN_WIDTH] = acc[k];
    end
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == LB_RATIO'(k)) merged[k*IN_WIDTH +: IN_WIDTH] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      for (int k = 0; k < RATIO - 1; k++) acc[k] <= '0;
    end else if (close_word) begin
      cnt       <= '0;
      out_valid <= 1'b1;
      out_data  <= merged;
      out_last  <= in_last;
      for (int k = 0; k < RATIO - 1; k++) acc[k] <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        cnt <= cnt + 1'b1;
        for (int k = 0; k < RATIO - 1; k++) begin
          if (cnt == LB_RATIO'(k)) acc[k] <= in_data;
        end
      end
    end
  end

`ifdef STREAM_PACKER_KEEP_EN
  logic [RATIO-1:0] keep_next;

  always_comb begin
    keep_next = '0;
    for (int k = 0; k < RATIO; k++) keep_next[k] = (LB_RATIO'(k) <= cnt);
  end

  // Keep mask follows the same load/clear timing as out_data.
  always_ff @(posedge clk) begin
    if (!rstn || clear) out_keep <= '0;
    else if (close_word) out_keep <= keep_next;
  end
`endif

endmodule
